// File: rtl/snn_pkg.sv
// Shared SNN core definitions: sizes, transmitter FSM states and the packet
// field layout that the scheduler SRAM also decodes.
package snn_pkg;

  localparam int N_NEURONS = 256;
  localparam int AXON_W    = 8;
  localparam int DELAY_W   = 4;
  localparam int PKT_W     = AXON_W + DELAY_W;
  localparam int AXON_LSB  = 4;
  localparam int DELAY_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } tx_state_e;

  function automatic logic [PKT_W-1:0] make_packet(input logic [AXON_W-1:0]  axon,
                                                   input logic [DELAY_W-1:0] dly);
    logic [PKT_W-1:0] p;
    p = '0;
    p[AXON_LSB +: AXON_W]   = axon;
    p[DELAY_LSB +: DELAY_W] = dly;
    return p;
  endfunction

endpackage

// File: rtl/spike_packet_tx_if.sv
// Packet valid/ready channel from the spike transmitter toward router/SRAM.
interface spike_packet_tx_if;
  logic [snn_pkg::PKT_W-1:0] packet;
  logic                      packet_valid;
  logic                      packet_ready;

  modport master (output packet, output packet_valid, input packet_ready);
  modport slave  (input packet, input packet_valid, output packet_ready);
endinterface

// File: rtl/spike_prio_enc.sv
// Combinational fixed-priority encoder: lowest set bit of the spike vector.
module spike_prio_enc
  import snn_pkg::*;
(
  input  logic [N_NEURONS-1:0] vec,
  output logic                 found,
  output logic [AXON_W-1:0]    index
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        index = AXON_W'(i);
      end
    end
  end

endmodule

// File: rtl/spike_packet_tx.sv
// Spike packet transmitter: one {axon, delay} packet per set spike, ascending.
// Optional SPIKE_TX_PKT_CNT_EN adds a per-frame handshake counter pkt_count.
//
// state | meaning
// IDLE  | waiting for tick
// SCAN  | first lookup of pending spikes
// SEND  | packet_valid held until accepted; next index loaded on handshake
// DONE  | one-cycle done pulse, then back to IDLE
module spike_packet_tx
  import snn_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic [N_NEURONS-1:0]  spikes,
  input  logic [DELAY_W-1:0]    delay,
  spike_packet_tx_if.master     tx,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
`ifdef SPIKE_TX_PKT_CNT_EN
  ,
  output logic [AXON_W:0]       pkt_count
`endif
);

  tx_state_e              state;
  logic [N_NEURONS-1:0]   pending;
  logic [DELAY_W-1:0]     delay_q;
  logic                   enc_found;
  logic [AXON_W-1:0]      enc_index;
  logic                   handshake;

  spike_prio_enc u_prio_enc (
    .vec   (pending),
    .found (enc_found),
    .index (enc_index)
  );

  assign handshake = tx.packet_valid & tx.packet_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      pending         <= '0;
      delay_q         <= '0;
      tx.packet       <= '0;
      tx.packet_valid <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (tick) begin
            pending <= spikes;
            delay_q <= delay;
            busy    <= 1'b1;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (enc_found) begin
            tx.packet          <= make_packet(enc_index, delay_q);
            tx.packet_valid    <= 1'b1;
            pending[enc_index] <= 1'b0;
            state              <= SEND;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        SEND: begin
          if (handshake) begin
            if (enc_found) begin
              tx.packet          <= make_packet(enc_index, delay_q);
              pending[enc_index] <= 1'b0;
            end else begin
              tx.packet_valid <= 1'b0;
              done            <= 1'b1;
              state           <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPIKE_TX_PKT_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
    end else if (state == IDLE && tick) begin
      pkt_count <= '0;
    end else if (state == SEND && handshake) begin
      pkt_count <= pkt_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spike_packet_tx.sv
// Directed self-checking bench for spike_packet_tx (sparse, backpressure,
// empty, overrun, full and mid-frame reset frames).
module tb_spike_packet_tx;
  import snn_pkg::*;

  logic                 clk;
  logic                 reset_n;
  logic                 tick;
  logic [N_NEURONS-1:0] spikes;
  logic [DELAY_W-1:0]   delay;
  logic                 busy;
  logic                 done;
  logic                 overrun;
`ifdef SPIKE_TX_PKT_CNT_EN
  logic [AXON_W:0]      pkt_count;
`endif

  int checks = 0;
  int errors = 0;

  spike_packet_tx_if pif ();

  spike_packet_tx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .spikes    (spikes),
    .delay     (delay),
    .tx        (pif),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
`ifdef SPIKE_TX_PKT_CNT_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse tick for one cycle; returns sampled in cycle T+1.
  task automatic fire(input logic [N_NEURONS-1:0] s, input logic [DELAY_W-1:0] d);
    spikes = s;
    delay  = d;
    tick   = 1'b1;
    step();
    tick   = 1'b0;
  endtask

  task automatic chk_pkt(input string tag, input logic [PKT_W-1:0] exp);
    chk({tag, "_valid"}, 32'(pif.packet_valid), 32'd1);
    chk({tag, "_pkt"}, 32'(pif.packet), 32'(exp));
  endtask

  initial begin
    logic [N_NEURONS-1:0] v;
    int n;
    int stray;
    bit seen_done;

    reset_n = 1'b0;
    tick = 1'b0;
    spikes = '0;
    delay = '0;
    pif.packet_ready = 1'b0;
    step();
    step();
    chk("rst_packet", 32'(pif.packet), 32'h0);
    chk("rst_valid", 32'(pif.packet_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    reset_n = 1'b1;
    step();

    // Sparse frame
    pif.packet_ready = 1'b1;
    v = '0; v[3] = 1'b1; v[200] = 1'b1; v[255] = 1'b1;
    fire(v, 4'd5);
    chk("sp_busy_t1", 32'(busy), 32'd1);
    chk("sp_valid_t1", 32'(pif.packet_valid), 32'd0);
    step(); chk_pkt("sp_p0", 12'h035);
    step(); chk_pkt("sp_p1", 12'hC85);
    step(); chk_pkt("sp_p2", 12'hFF5);
    step();
    chk("sp_done", 32'(done), 32'd1);
    chk("sp_valid_end", 32'(pif.packet_valid), 32'd0);
    step();
    chk("sp_done_clr", 32'(done), 32'd0);
    chk("sp_busy_clr", 32'(busy), 32'd0);

    // Backpressure
    pif.packet_ready = 1'b0;
    v = '0; v[0] = 1'b1; v[1] = 1'b1;
    fire(v, 4'd0);
    step(); chk_pkt("bp_hold0", 12'h000);
    step(); chk_pkt("bp_hold1", 12'h000);
    step(); chk_pkt("bp_hold2", 12'h000);
    step(); chk_pkt("bp_hold3", 12'h000);
    pif.packet_ready = 1'b1;
    step(); chk_pkt("bp_next", 12'h010);
    step();
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_valid_end", 32'(pif.packet_valid), 32'd0);
    step();

    // Empty frame
    fire('0, 4'd7);
    chk("em_busy_t1", 32'(busy), 32'd1);
    chk("em_done_t1", 32'(done), 32'd0);
    chk("em_valid_t1", 32'(pif.packet_valid), 32'd0);
    step();
    chk("em_busy_t2", 32'(busy), 32'd1);
    chk("em_done_t2", 32'(done), 32'd1);
    chk("em_valid_t2", 32'(pif.packet_valid), 32'd0);
    step();
    chk("em_busy_t3", 32'(busy), 32'd0);
    chk("em_done_t3", 32'(done), 32'd0);
    chk("em_overrun", 32'(overrun), 32'd0);

    // Overrun: second tick during SEND must not disturb the frame
    v = '0; v[10] = 1'b1; v[20] = 1'b1; v[30] = 1'b1; v[40] = 1'b1;
    fire(v, 4'd2);
    step(); chk_pkt("ov_p0", 12'h0A2);
    spikes = '1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("ov_flag", 32'(overrun), 32'd1);
    chk_pkt("ov_p1", 12'h142);
    step(); chk_pkt("ov_p2", 12'h1E2);
    step(); chk_pkt("ov_p3", 12'h282);
    step();
    chk("ov_done", 32'(done), 32'd1);
    chk("ov_valid_end", 32'(pif.packet_valid), 32'd0);
    step();
    chk("ov_busy_clr", 32'(busy), 32'd0);
    step();
    chk("ov_no_frame", 32'(busy), 32'd0);
    chk("ov_sticky", 32'(overrun), 32'd1);

    // Full frame
    fire('1, 4'hF);
    n = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 300 && !seen_done; c++) begin
      step();
      if (pif.packet_valid) begin
        chk("full_pkt", 32'(pif.packet), 32'({n[7:0], 4'hF}));
        n++;
      end
      if (done) seen_done = 1'b1;
    end
    chk("full_count", 32'(n), 32'd256);
    chk("full_done", 32'(seen_done), 32'd1);
`ifdef SPIKE_TX_PKT_CNT_EN
    chk("full_pkt_count", 32'(pkt_count), 32'd256);
`endif
    step();

    // Reset mid-frame
    pif.packet_ready = 1'b0;
    v = '0; v[5] = 1'b1; v[6] = 1'b1; v[7] = 1'b1;
    fire(v, 4'd9);
    step();
    chk_pkt("mr_pre", 12'h059);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_packet", 32'(pif.packet), 32'h0);
    chk("mr_valid", 32'(pif.packet_valid), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_done", 32'(done), 32'h0);
    chk("mr_overrun", 32'(overrun), 32'h0);
    step();
    #3 reset_n = 1'b1;
    pif.packet_ready = 1'b1;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (pif.packet_valid || busy) stray++;
    end
    chk("mr_no_stale", 32'(stray), 32'd0);
    chk("mr_overrun_after", 32'(overrun), 32'd0);
`ifdef SPIKE_TX_PKT_CNT_EN
    chk("mr_pkt_count", 32'(pkt_count), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_packet_tx.md
# spike_packet_tx

Spike packet transmitter for the sequential SNN core. At each tick, it captures the 256-bit neuron spike vector from the neuron array. It then emits one 12-bit packet per set bit, in ascending neuron order, over a valid/ready handshake toward the router and scheduler SRAM write port. It is the sending end of the packet format the scheduler consumes: axon index in [11:4], delay in [3:0].

## Interface
- N_NEURONS, 256, width of the spike vector and number of neurons scanned.
- AXON_W, 8, axon index field width; must equal log2(N_NEURONS).
- DELAY_W, 4, delay field width; packet width is AXON_W+DELAY_W.
- clk  in  1  core clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- tick  in  1  single-cycle pulse: capture spikes/delay and start a frame.
- spikes  in  N_NEURONS  neuron fire flags, sampled only on an accepted tick.
- delay  in  DELAY_W  delay field for all packets of the frame, sampled with spikes.
- packet_ready  in  1  downstream accepts packet this cycle.
- packet  out  AXON_W+DELAY_W  {axon_index, delay}.
- packet_valid  out  1  packet holds a valid packet.
- busy  out  1  frame in progress (state not IDLE).
- done  out  1  one-cycle pulse at frame end.
- overrun  out  1  sticky: tick arrived while busy; cleared only by reset.

## Operation
- FSM states: IDLE, SCAN, SEND, DONE.
- IDLE + tick:
  - latch spikes into the pending register and delay into delay_q;
  - go to SCAN.
- SCAN:
  - fixed-priority encoder finds the lowest set index in pending;
  - if found: load packet = {index, delay_q}, clear that pending bit, set packet_valid, go to SEND;
  - if pending is zero: go to DONE.
- SEND:
  - packet and packet_valid hold stable until packet_valid & packet_ready;
  - on that handshake with pending nonzero: load the next lowest index in the same cycle and stay in SEND (back-to-back, 1 packet/cycle);
  - on that handshake with pending zero: drop packet_valid and go to DONE.
- DONE: assert done for one cycle, then go to IDLE.
- A tick in any state other than IDLE is ignored (spikes not sampled) and sets overrun.
- A tick in DONE also counts as overrun.
- An all-zero spike vector gives IDLE→SCAN→DONE→IDLE with no packets.
- Delay semantics belong to the receiver: field value d lands d+1 ticks later, modulo 16. The transmitter passes the field through unmodified.
- Reset mid-frame: the frame is abandoned, pending is cleared and no further packets are sent.
- Reset values: packet=0, packet_valid=0, busy=0, done=0, overrun=0, state=IDLE.

## Timing
- tick at cycle T → SCAN at T+1 → first packet_valid at T+2.
- With packet_ready held high, k spikes produce packets on cycles T+2 … T+k+1.
- done pulses at T+k+2.
- Zero spikes: done at T+2.
- packet_valid must not fall without a handshake (AXI-style rule).
- packet_ready may toggle freely; it has no combinational path to packet_valid.
- The priority encoder is combinational over N_NEURONS bits. It is the critical path, and pending is registered.

## Configuration
- SPIKE_TX_PKT_CNT_EN:
  - defined: adds output pkt_count [AXON_W:0];
  - pkt_count is cleared on an accepted tick and increments on each handshake;
  - it holds its final value after done until the next accepted tick; reset value 0.
- Undefined: no port and no counter logic; all other behaviour is identical.

## Structure
- Shared package snn_pkg holds:
  - N_NEURONS, AXON_W, DELAY_W, PKT_W;
  - the FSM state enum;
  - the packet field offsets (AXON_LSB=4, DELAY_LSB=0), shared with the scheduler SRAM.
- One sub-module: spike_prio_enc. Input is the N_NEURONS vector; outputs are found and index[AXON_W-1:0] (lowest set bit). It is purely combinational.

## Test plan
- Reset mid-frame:
  - stimulus: assert reset_n low during SEND;
  - required: all outputs zero immediately;
  - required: after release, no stale packets and overrun=0.
- Sparse frame:
  - stimulus: spikes bits {3,200,255}, delay=5, ready=1;
  - required: packets 0x035, 0xC85, 0xFF5 on consecutive cycles;
  - required: done one cycle after the last packet.
- Backpressure:
  - stimulus: spikes bits {0,1}, delay=0; ready low for 3 cycles after first valid;
  - required: packet 0x000 held stable 3 cycles, then 0x010 follows the handshake.
- Empty frame:
  - stimulus: spikes=0;
  - required: no packet_valid, done at T+2, busy high only T+1..T+2.
- Overrun:
  - stimulus: second tick during SEND of a 4-spike frame;
  - required: overrun=1 (sticky); the original frame completes with exactly 4 packets.
- Full frame:
  - stimulus: all 256 bits set, delay=15, ready=1;
  - required: 256 packets with indices 0..255 in order, all delay F;
  - required: with SPIKE_TX_PKT_CNT_EN, pkt_count=256.
